// File: rtl/yl3_serial_receiver.sv
// ---------------------------------------------------------------------------
// yl3_serial_receiver
//   Receive side of the YL-3 dual-74HC595 serial link (SER / SRCLK / RCLK).
//   The three asynchronous pins are synchronized into the CLK domain. Each
//   16-bit frame {position, segments} is rebuilt MSB first and presented with
//   a one-cycle VALID strobe.
//
//   Optional feature macro: YL3_RX_DIGIT_MEM_EN
//     defined   : an 8x8 digit memory captures the segments of every clean
//                 frame at the digit it addresses; RD_DATA = mem[RD_ADDR].
//     undefined : no memory; RD_DATA is tied to 8'hFF and RD_ADDR is ignored.
//
//   Output handshake: VALID is a one-cycle strobe with no ready/back-pressure.
//   DATA_OUT, SEG_OUT, DIGIT_IDX, FRAME_ERR and POS_ERR are meaningful in the
//   VALID cycle; DATA_OUT/SEG_OUT/DIGIT_IDX then hold until the next VALID,
//   while FRAME_ERR/POS_ERR return to 0. The consumer must capture the frame
//   in the VALID cycle.
// ---------------------------------------------------------------------------
module yl3_serial_receiver #(
  parameter int SYNC_STAGES = 2,  // legal range 2..4
  parameter int FRAME_BITS  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SER_IN,
  input  logic                  SRCLK_IN,
  input  logic                  RCLK_IN,
  output logic [FRAME_BITS-1:0] DATA_OUT,
  output logic                  VALID,
  output logic                  FRAME_ERR,
  output logic                  POS_ERR,
  output logic [2:0]            DIGIT_IDX,
  output logic [7:0]            SEG_OUT,
  input  logic [2:0]            RD_ADDR,
  output logic [7:0]            RD_DATA
);

  // -------------------------------------------------------------------------
  // Pin synchronizers and edge-detect history
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ser_sync;
  logic [SYNC_STAGES-1:0] srclk_sync;
  logic [SYNC_STAGES-1:0] rclk_sync;
  logic                   srclk_hist;
  logic                   rclk_hist;

  logic ser_s;
  logic srclk_s;
  logic rclk_s;
  logic srclk_rise;
  logic rclk_rise;

  // Flop chains bring each pin into CLK; all three share the same latency so
  // the order of pin events is preserved.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ser_sync   <= '0;
      srclk_sync <= '0;
      rclk_sync  <= '0;
    end else begin
      ser_sync   <= {ser_sync[SYNC_STAGES-2:0],   SER_IN};
      srclk_sync <= {srclk_sync[SYNC_STAGES-2:0], SRCLK_IN};
      rclk_sync  <= {rclk_sync[SYNC_STAGES-2:0],  RCLK_IN};
    end
  end

  // One history flop per clock pin turns the synchronized level into a
  // single-cycle rising-edge event.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      srclk_hist <= 1'b0;
      rclk_hist  <= 1'b0;
    end else begin
      srclk_hist <= srclk_s;
      rclk_hist  <= rclk_s;
    end
  end

  assign ser_s      = ser_sync[SYNC_STAGES-1];
  assign srclk_s    = srclk_sync[SYNC_STAGES-1];
  assign rclk_s     = rclk_sync[SYNC_STAGES-1];
  assign srclk_rise = srclk_s & ~srclk_hist;
  assign rclk_rise  = rclk_s & ~rclk_hist;

  // -------------------------------------------------------------------------
  // Shift register and bit counter
  // -------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] shift_q;
  logic [4:0]            bit_cnt;
  logic [4:0]            cnt_inc;

  // Count of bits since the last latch, saturating so very long frames can
  // never wrap back onto a "correct" count.
  assign cnt_inc = (bit_cnt == 5'd31) ? 5'd31 : bit_cnt + 5'd1;

  // SRCLK shifts SER in at the LSB end; the oldest bits fall off the top, so
  // an over-long frame keeps only its last FRAME_BITS bits. On RCLK the count
  // restarts; if SRCLK rose in the same cycle that bit belongs to the next
  // frame, so the count restarts at 1 (74HC595 behaviour with tied clocks).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      if (srclk_rise) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], ser_s};
      end
      if (rclk_rise) begin
        bit_cnt <= srclk_rise ? 5'd1 : 5'd0;
      end else if (srclk_rise) begin
        bit_cnt <= cnt_inc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Position decode of the frame being latched
  // -------------------------------------------------------------------------
  logic [7:0] pos_bits;
  logic [3:0] pos_cnt;
  logic [2:0] pos_idx;
  logic       pos_bad;
  logic       cnt_bad;

  assign pos_bits = shift_q[FRAME_BITS-1:FRAME_BITS-8];

  // Count set position bits and remember the index of the set one; the index
  // is only trusted when exactly one bit is set.
  always_comb begin
    pos_cnt = 4'd0;
    pos_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pos_bits[i]) begin
        pos_cnt = pos_cnt + 4'd1;
        pos_idx = 3'(i);
      end
    end
  end

  assign pos_bad = (pos_cnt != 4'd1);
  // Evaluated on the pre-increment count, which is what a same-cycle SRCLK
  // edge requires as well.
  assign cnt_bad = (bit_cnt != 5'(FRAME_BITS));

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  // On RCLK the pre-shift register contents are latched; status strobes only
  // accompany VALID and otherwise sit at 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DATA_OUT  <= '0;
      SEG_OUT   <= '0;
      DIGIT_IDX <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      POS_ERR   <= 1'b0;
    end else begin
      VALID     <= rclk_rise;
      FRAME_ERR <= rclk_rise & cnt_bad;
      POS_ERR   <= rclk_rise & pos_bad;
      if (rclk_rise) begin
        DATA_OUT  <= shift_q;
        SEG_OUT   <= shift_q[7:0];
        DIGIT_IDX <= pos_bad ? 3'd0 : pos_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional digit memory
  // -------------------------------------------------------------------------
`ifdef YL3_RX_DIGIT_MEM_EN
  logic [7:0] digit_mem [8];

  // Clean frames store their segments at the digit they address; frames with
  // either error flag leave the memory untouched. Reset blanks every digit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) begin
        digit_mem[i] <= 8'hFF;
      end
    end else if (VALID && !POS_ERR && !FRAME_ERR) begin
      digit_mem[DIGIT_IDX] <= SEG_OUT;
    end
  end

  assign RD_DATA = digit_mem[RD_ADDR];
`else
  logic unused_rd_addr;

  // Without the memory every digit reads as blank.
  assign unused_rd_addr = ^RD_ADDR;
  assign RD_DATA        = 8'hFF;
`endif

endmodule

// File: tb/tb_yl3_serial_receiver.sv
// ---------------------------------------------------------------------------
// tb_yl3_serial_receiver
//   Drives the YL-3 pins with randomized level timing, keeps a reference model
//   of the link (all bits ever shifted, bits since latch, digit memory) and
//   checks every VALID from a separate monitor through an expected queue.
// ---------------------------------------------------------------------------
module tb_yl3_serial_receiver;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        SER_IN;
  logic        SRCLK_IN;
  logic        RCLK_IN;
  logic [15:0] DATA_OUT;
  logic        VALID;
  logic        FRAME_ERR;
  logic        POS_ERR;
  logic [2:0]  DIGIT_IDX;
  logic [7:0]  SEG_OUT;
  logic [2:0]  RD_ADDR;
  logic [7:0]  RD_DATA;

  always #5 CLK = ~CLK;

  yl3_serial_receiver #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SER_IN    (SER_IN),
    .SRCLK_IN  (SRCLK_IN),
    .RCLK_IN   (RCLK_IN),
    .DATA_OUT  (DATA_OUT),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .POS_ERR   (POS_ERR),
    .DIGIT_IDX (DIGIT_IDX),
    .SEG_OUT   (SEG_OUT),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  // {frame_err, pos_err, digit_idx[2:0], data[15:0]}
  logic [20:0] exp_q[$];

  // reference model
  logic       all_bits[$];   // every bit shifted since reset, oldest first
  int         since_latch;   // bits shifted since the last latch
  logic [7:0] m_mem [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    all_bits.delete();
    since_latch = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 8'hFF;
  endtask

  task automatic model_bit(input logic b);
    all_bits.push_back(b);
    since_latch++;
  endtask

  // The latched frame is the most recent 16 bits (zeros before the first
  // bit after reset); it is checked for length and a single position bit.
  task automatic model_latch();
    logic [15:0] data;
    logic [7:0]  pos;
    logic        fe;
    logic        pe;
    logic [2:0]  idx;
    int          n;
    int          k;
    n = all_bits.size();
    data = '0;
    for (int i = 0; i < 16; i++) begin
      k = n - 16 + i;
      data[15-i] = (k >= 0) ? all_bits[k] : 1'b0;
    end
    pos = data[15:8];
    fe  = (since_latch != 16);
    pe  = ($countones(pos) != 1);
    idx = 3'd0;
    if (!pe) begin
      for (int i = 0; i < 8; i++) if (pos[i]) idx = 3'(i);
    end
    exp_q.push_back({fe, pe, idx, data});
    if (!fe && !pe) m_mem[idx] = data[7:0];
    since_latch = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    SER_IN = b;
    wait_cyc($urandom_range(7, 9));
    SRCLK_IN = 1'b1;
    model_bit(b);
    wait_cyc($urandom_range(6, 8));
    SRCLK_IN = 1'b0;
  endtask

  task automatic latch();
    RCLK_IN = 1'b1;
    model_latch();
    wait_cyc($urandom_range(6, 8));
    RCLK_IN = 1'b0;
    wait_cyc($urandom_range(6, 8));
  endtask

  // SRCLK and RCLK rise together: the latch sees the pre-shift contents.
  task automatic tied_bit(input logic b);
    SER_IN = b;
    wait_cyc($urandom_range(7, 9));
    SRCLK_IN = 1'b1;
    RCLK_IN  = 1'b1;
    model_latch();
    model_bit(b);
    wait_cyc($urandom_range(6, 8));
    SRCLK_IN = 1'b0;
    RCLK_IN  = 1'b0;
  endtask

  // Sends the low nbits of v MSB first; bits above 15 are random filler.
  task automatic send_bits(input logic [15:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i < 16) send_bit(v[i]);
      else        send_bit(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input logic [15:0] v, input int nbits);
    send_bits(v, nbits);
    latch();
  endtask

  task automatic check_mem(input string tag);
    logic [7:0] e;
    for (int a = 0; a < 8; a++) begin
      @(negedge CLK);
      RD_ADDR = 3'(a);
      #1;
`ifdef YL3_RX_DIGIT_MEM_EN
      e = m_mem[a];
`else
      e = 8'hFF;
`endif
      chk($sformatf("%s_rd_data[%0d]", tag, a), RD_DATA, e);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    model_reset();
    wait_cyc(3);
    chk("rst_data_out",  DATA_OUT,  0);
    chk("rst_valid",     VALID,     0);
    chk("rst_frame_err", FRAME_ERR, 0);
    chk("rst_pos_err",   POS_ERR,   0);
    chk("rst_digit_idx", DIGIT_IDX, 0);
    chk("rst_seg_out",   SEG_OUT,   0);
    chk("rst_rd_data",   RD_DATA,   8'hFF);
    RST_N = 1'b1;
    wait_cyc(3);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    chk($sformatf("%s_pending", tag), exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [20:0] e;
    if (RST_N === 1'b1 && VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("stray_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data_out",  DATA_OUT,  e[15:0]);
        chk("seg_out",   SEG_OUT,   e[7:0]);
        chk("digit_idx", DIGIT_IDX, e[18:16]);
        chk("pos_err",   POS_ERR,   e[19]);
        chk("frame_err", FRAME_ERR, e[20]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v;
    int          nb;
    int          kind;
    RST_N    = 1'b0;
    SER_IN   = 1'b0;
    SRCLK_IN = 1'b0;
    RCLK_IN  = 1'b0;
    RD_ADDR  = 3'd0;
    model_reset();
    do_reset();

    // directed frames
    send_frame(16'h80C0, 16);
    send_frame(16'h0100, 15);
    send_frame(16'h01F9, 16);
    send_frame(16'h0399, 16);
    drain("directed");
    check_mem("directed");

    // tied clocks: 17 edges carrying 16'h20A4 then a pad bit
    for (int i = 15; i >= 0; i--) begin
      v = 16'h20A4;
      tied_bit(v[i]);
    end
    tied_bit(1'b0);
    wait_cyc(8);
    drain("tied");

    // reset after 8 bits, then a full frame
    send_bits(16'h4092, 8);
    do_reset();
    send_frame(16'h4092, 16);
    drain("post_reset");
    check_mem("post_reset");

    // two clean frames into fresh memory
    do_reset();
    send_frame(16'h0140, 16);
    send_frame(16'h8079, 16);
    drain("mem_pair");
    check_mem("mem_pair");

    // randomized frames of mixed length and position validity
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 3);
      if (kind < 3) v = {8'(1 << $urandom_range(0, 7)), 8'($urandom_range(0, 255))};
      else          v = 16'($urandom_range(0, 65535));
      nb = ($urandom_range(0, 9) < 7) ? 16 : $urandom_range(14, 18);
      send_frame(v, nb);
    end
    drain("random");
    check_mem("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
